// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the combinational ALU.
// Holds one decoded instruction under a valid/ready handshake, resolves
// MEM/WB forwarding on the held register indices, and presents the ALU
// operands and control code. A taken branch flushes the held instruction.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            flush,
  input  logic [1:0]      alu_op_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7b5_i,
  input  logic            op5_i,
  input  logic            alu_src_i,
  input  logic [XLEN-1:0] rd1_i,
  input  logic [XLEN-1:0] rd2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [REGW-1:0] rs1_i,
  input  logic [REGW-1:0] rs2_i,
  input  logic [REGW-1:0] rd_i,
  input  logic [REGW-1:0] mem_rd_i,
  input  logic [REGW-1:0] wb_rd_i,
  input  logic            mem_regwrite_i,
  input  logic            wb_regwrite_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic [XLEN-1:0] wb_result_i,
  output logic [2:0]      alu_control_o,
  output logic [XLEN-1:0] src_a_o,
  output logic [XLEN-1:0] src_b_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [REGW-1:0] rd_o,
  output logic            illegal_o
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [2:0]      dec_ctrl;
  logic            dec_illegal;
  logic            capture;

  logic            valid_q;
  logic [2:0]      ctrl_q;
  logic            illegal_q;
  logic [XLEN-1:0] rd1_q;
  logic [XLEN-1:0] rd2_q;
  logic [XLEN-1:0] imm_q;
  logic            alu_src_q;
  logic [REGW-1:0] rs1_q;
  logic [REGW-1:0] rs2_q;
  logic [REGW-1:0] rd_q;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  // Single-entry register: free when empty or when it drains this cycle.
  assign in_ready = !valid_q || out_ready;

  // Flush wins over capture so a killed cycle never loads the new instruction.
  assign capture = in_valid && in_ready && !flush;

  // Decode ALUOp/funct3/funct7b5 into the ALU control code.
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_illegal = 1'b0;
    case (alu_op_i)
      2'b00: dec_ctrl = ALU_ADD;
      2'b01: dec_ctrl = ALU_SUB;
      2'b10: begin
        case (funct3_i)
          3'b000:  dec_ctrl = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  dec_ctrl = ALU_SLT;
          3'b110:  dec_ctrl = ALU_OR;
          3'b111:  dec_ctrl = ALU_AND;
          default: begin
            dec_ctrl    = ALU_ADD;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctrl    = ALU_ADD;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Valid bit: flush kills, capture fills, downstream acceptance drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Payload: loads on capture, otherwise holds; flush only clears illegal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= ALU_ADD;
      illegal_q <= 1'b0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      alu_src_q <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
    end else if (capture) begin
      ctrl_q    <= dec_ctrl;
      illegal_q <= dec_illegal;
      rd1_q     <= rd1_i;
      rd2_q     <= rd2_i;
      imm_q     <= imm_i;
      alu_src_q <= alu_src_i;
      rs1_q     <= rs1_i;
      rs2_q     <= rs2_i;
      rd_q      <= rd_i;
    end else if (flush) begin
      illegal_q <= 1'b0;
    end
  end

  // Forwarding on the held sources: MEM is younger so it beats WB; x0 never forwards.
  always_comb begin
    fwd_a = rd1_q;
    if (rs1_q != '0 && mem_regwrite_i && mem_rd_i == rs1_q) begin
      fwd_a = mem_result_i;
    end else if (rs1_q != '0 && wb_regwrite_i && wb_rd_i == rs1_q) begin
      fwd_a = wb_result_i;
    end

    fwd_b = rd2_q;
    if (rs2_q != '0 && mem_regwrite_i && mem_rd_i == rs2_q) begin
      fwd_b = mem_result_i;
    end else if (rs2_q != '0 && wb_regwrite_i && wb_rd_i == rs2_q) begin
      fwd_b = wb_result_i;
    end
  end

  assign out_valid     = valid_q;
  assign alu_control_o = ctrl_q;
  assign illegal_o     = illegal_q;
  assign rd_o          = rd_q;
  assign src_a_o       = fwd_a;
  assign store_data_o  = fwd_b;
  assign src_b_o       = alu_src_q ? imm_q : fwd_b;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: an instruction-level model checked every
// cycle, plus literal expectations for the directed cases.
module tb_alu_issue_stage;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid, in_ready, out_valid, out_ready, flush;
  logic [1:0]      alu_op_i;
  logic [2:0]      funct3_i;
  logic            funct7b5_i, op5_i, alu_src_i;
  logic [XLEN-1:0] rd1_i, rd2_i, imm_i;
  logic [REGW-1:0] rs1_i, rs2_i, rd_i, mem_rd_i, wb_rd_i;
  logic            mem_regwrite_i, wb_regwrite_i;
  logic [XLEN-1:0] mem_result_i, wb_result_i;
  logic [2:0]      alu_control_o;
  logic [XLEN-1:0] src_a_o, src_b_o, store_data_o;
  logic [REGW-1:0] rd_o;
  logic            illegal_o;

  int errors = 0;
  int checks = 0;

  alu_issue_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .alu_op_i(alu_op_i), .funct3_i(funct3_i), .funct7b5_i(funct7b5_i),
    .op5_i(op5_i), .alu_src_i(alu_src_i),
    .rd1_i(rd1_i), .rd2_i(rd2_i), .imm_i(imm_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .mem_rd_i(mem_rd_i), .wb_rd_i(wb_rd_i),
    .mem_regwrite_i(mem_regwrite_i), .wb_regwrite_i(wb_regwrite_i),
    .mem_result_i(mem_result_i), .wb_result_i(wb_result_i),
    .alu_control_o(alu_control_o), .src_a_o(src_a_o), .src_b_o(src_b_o),
    .store_data_o(store_data_o), .rd_o(rd_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef struct packed {
    logic [2:0]  ctrl;
    logic        ill;
    logic [31:0] rd1, rd2, imm;
    logic        use_imm;
    logic [4:0]  rs1, rs2, rd;
  } instr_t;

  logic   m_valid;
  instr_t m_ins;

  // Mnemonic-level decode: ADD=0 SUB=1 AND=2 OR=3 SLT=5, unsupported -> ADD + illegal.
  function automatic instr_t decode_in();
    instr_t t;
    string  mn;
    if (alu_op_i == 2'd0)      mn = "add";
    else if (alu_op_i == 2'd1) mn = "sub";
    else if (alu_op_i == 2'd3) mn = "bad";
    else if (funct3_i == 3'd0) mn = (op5_i && funct7b5_i) ? "sub" : "add";
    else if (funct3_i == 3'd2) mn = "slt";
    else if (funct3_i == 3'd6) mn = "or";
    else if (funct3_i == 3'd7) mn = "and";
    else                       mn = "bad";
    t.ill  = (mn == "bad");
    t.ctrl = (mn == "sub") ? 3'd1 : (mn == "and") ? 3'd2 : (mn == "or") ? 3'd3 :
             (mn == "slt") ? 3'd5 : 3'd0;
    t.rd1 = rd1_i; t.rd2 = rd2_i; t.imm = imm_i; t.use_imm = alu_src_i;
    t.rs1 = rs1_i; t.rs2 = rs2_i; t.rd = rd_i;
    return t;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] regval);
    if (rs == 0) return regval;
    if (mem_regwrite_i && mem_rd_i == rs) return mem_result_i;
    if (wb_regwrite_i && wb_rd_i == rs) return wb_result_i;
    return regval;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_ins   <= '0;
    end else if (flush) begin
      m_valid     <= 1'b0;
      m_ins.ill   <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_ins   <= decode_in();
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      check("out_valid", out_valid, m_valid);
      check("in_ready", in_ready, !m_valid || out_ready);
      check("illegal", illegal_o, m_ins.ill);
      if (m_valid) begin
        check("alu_control", alu_control_o, m_ins.ctrl);
        check("src_a", src_a_o, operand(m_ins.rs1, m_ins.rd1));
        check("store_data", store_data_o, operand(m_ins.rs2, m_ins.rd2));
        check("src_b", src_b_o, m_ins.use_imm ? m_ins.imm : operand(m_ins.rs2, m_ins.rd2));
        check("rd", rd_o, m_ins.rd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [2:0] f3, input logic o5,
                           input logic f7, input logic src, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] im,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    alu_op_i = op; funct3_i = f3; op5_i = o5; funct7b5_i = f7; alu_src_i = src;
    rd1_i = a; rd2_i = b; imm_i = im; rs1_i = s1; rs2_i = s2; rd_i = d;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic       o5;
    logic       f7;
    logic [2:0] ctrl;
    logic       ill;
  } dec_vec_t;

  dec_vec_t sweep[8];

  initial begin
    sweep[0] = '{2'd2, 3'd2, 1'b1, 1'b0, 3'd5, 1'b0};
    sweep[1] = '{2'd2, 3'd6, 1'b1, 1'b0, 3'd3, 1'b0};
    sweep[2] = '{2'd2, 3'd7, 1'b0, 1'b0, 3'd2, 1'b0};
    sweep[3] = '{2'd2, 3'd1, 1'b1, 1'b0, 3'd0, 1'b1};
    sweep[4] = '{2'd1, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0};
    sweep[5] = '{2'd3, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1};
    sweep[6] = '{2'd2, 3'd4, 1'b1, 1'b0, 3'd0, 1'b1};
    sweep[7] = '{2'd0, 3'd7, 1'b1, 1'b1, 3'd0, 1'b0};

    in_valid = 0; out_ready = 1; flush = 0;
    set_instr(2'd0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    mem_rd_i = 0; wb_rd_i = 0; mem_regwrite_i = 0; wb_regwrite_i = 0;
    mem_result_i = 0; wb_result_i = 0;

    #1 rst = 1'b0;
    #20;
    check("reset out_valid", out_valid, 1'b0);
    check("reset alu_control", alu_control_o, 3'b000);
    check("reset illegal", illegal_o, 1'b0);
    check("reset src_a", src_a_o, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    cyc(1);
    check("in_ready after reset", in_ready, 1'b1);

    // R-type sub then I-type with the same funct7b5.
    in_valid = 1;
    set_instr(2'd2, 3'd0, 1, 1, 0, 32'd7, 32'd3, 32'd0, 5'd1, 5'd2, 5'd3);
    cyc(1);
    check("rsub ctrl", alu_control_o, 3'b001);
    check("rsub src_a", src_a_o, 32'd7);
    check("rsub src_b", src_b_o, 32'd3);
    set_instr(2'd2, 3'd0, 0, 1, 1, 32'd7, 32'd3, 32'd9, 5'd1, 5'd2, 5'd3);
    cyc(1);
    check("iadd ctrl", alu_control_o, 3'b000);
    check("iadd src_b", src_b_o, 32'd9);

    // Decode sweep.
    for (int i = 0; i < 8; i++) begin
      set_instr(sweep[i].op, sweep[i].f3, sweep[i].o5, sweep[i].f7, 0,
                32'h100 + i, 32'h200 + i, 32'h0, 5'd4, 5'd6, 5'(i + 1));
      cyc(1);
      check("sweep ctrl", alu_control_o, sweep[i].ctrl);
      check("sweep illegal", illegal_o, sweep[i].ill);
    end

    // Forwarding priority while stalled.
    set_instr(2'd0, 3'd0, 0, 0, 0, 32'h11, 32'h22, 32'h0, 5'd5, 5'd5, 5'd7);
    cyc(1);
    in_valid = 0; out_ready = 0;
    mem_rd_i = 5; wb_rd_i = 5; mem_regwrite_i = 1; wb_regwrite_i = 1;
    mem_result_i = 32'hAAAA; wb_result_i = 32'hBBBB;
    #1;
    check("fwd mem src_a", src_a_o, 32'hAAAA);
    check("fwd mem store", store_data_o, 32'hAAAA);
    cyc(1);
    mem_regwrite_i = 0;
    #1;
    check("fwd wb src_a", src_a_o, 32'hBBBB);
    cyc(1);
    out_ready = 1; in_valid = 1;
    set_instr(2'd0, 3'd0, 0, 0, 0, 32'h33, 32'h44, 32'h0, 5'd0, 5'd5, 5'd8);
    cyc(1);
    check("x0 no fwd src_a", src_a_o, 32'h33);
    check("x0 wb store", store_data_o, 32'hBBBB);

    // Immediate select with forwarded rs2.
    mem_rd_i = 6; mem_regwrite_i = 1; mem_result_i = 32'h10; wb_regwrite_i = 0;
    set_instr(2'd0, 3'd0, 0, 0, 1, 32'h1, 32'h2, 32'hFFFF_FFFC, 5'd9, 5'd6, 5'd10);
    cyc(1);
    check("imm src_b", src_b_o, 32'hFFFF_FFFC);
    check("imm store", store_data_o, 32'h10);
    mem_regwrite_i = 0;

    // Stall for 3 cycles with a new instruction waiting.
    set_instr(2'd1, 3'd0, 0, 0, 0, 32'hA1, 32'hA2, 32'h0, 5'd11, 5'd12, 5'd13);
    cyc(1);
    out_ready = 0;
    set_instr(2'd2, 3'd7, 1, 0, 0, 32'hB1, 32'hB2, 32'h0, 5'd14, 5'd15, 5'd16);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall in_ready", in_ready, 1'b0);
      check("stall src_a", src_a_o, 32'hA1);
      check("stall ctrl", alu_control_o, 3'b001);
      cyc(1);
    end
    out_ready = 1;
    cyc(1);
    check("post-stall src_a", src_a_o, 32'hB1);
    check("post-stall ctrl", alu_control_o, 3'b010);

    // Flush with a colliding capture, on an illegal latched op.
    set_instr(2'd3, 3'd0, 0, 0, 0, 32'hC1, 32'hC2, 32'h0, 5'd17, 5'd18, 5'd19);
    cyc(1);
    check("pre-flush illegal", illegal_o, 1'b1);
    flush = 1;
    set_instr(2'd1, 3'd0, 0, 0, 0, 32'hD1, 32'hD2, 32'h0, 5'd20, 5'd21, 5'd22);
    cyc(1);
    check("flush out_valid", out_valid, 1'b0);
    check("flush illegal", illegal_o, 1'b0);
    check("flush no capture rd", rd_o, 5'd19);
    flush = 0; in_valid = 0;
    cyc(1);
    check("after flush out_valid", out_valid, 1'b0);

    // Reset asserted mid-stall.
    in_valid = 1;
    set_instr(2'd1, 3'd0, 0, 0, 0, 32'hE1, 32'hE2, 32'h0, 5'd23, 5'd24, 5'd25);
    cyc(1);
    in_valid = 0; out_ready = 0;
    #2;
    check("stalled before reset", out_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 1'b0);
    check("midreset ctrl", alu_control_o, 3'b000);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    check("in_ready after release", in_ready, 1'b1);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
